// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the 16-bit RISC datapath.
// Build option: define CTRL_ILLEGAL_HALT_EN to trap undecodable opcodes in HALT.
module multicycle_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ST_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WIDTH-1:0]   opcode,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               Imm_5or8,
  output logic               RegWrite,
  output logic               OutREn,
  output logic               Branch,
  output logic               PSWEn,
  output logic               PCWrite,
  output logic               IorD,
  output logic               RegDst,
  output logic               LLorLH,
  output logic               ALUSrcA,
  output logic               JAorJR,
  output logic [1:0]         ALUop,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ST_BITS-1:0] state,
  output logic               illegal
);

  typedef enum logic [ST_BITS-1:0] {
    IDLE   = 0,
    FETCH  = 1,
    DECODE = 2,
    EXEC   = 3,
    MEM    = 4,
    WB     = 5,
    HALT   = 6
  } state_t;

  state_t cur, nxt, done_nxt;

  logic [4:0] op;
  logic [1:0] func;
  logic is_alu, is_lhi, is_lli, is_ldri, is_ldrr, is_stri, is_strr, is_cmp;
  logic is_addi, is_subi, is_mov, is_jmp, is_b, is_out;
  logic is_ldr, is_str, imm5_op, known;
  logic       ex_srca;
  logic [1:0] ex_srcb, ex_aluop;
  logic       unused_opcode_bits;

  assign op   = opcode[15:11];
  assign func = opcode[1:0];
  assign unused_opcode_bits = ^opcode[10:2];

  assign is_alu  = (op == 5'b00000);
  assign is_lhi  = (op == 5'b00001);
  assign is_lli  = (op == 5'b00010);
  assign is_ldri = (op == 5'b00011);
  assign is_ldrr = (op == 5'b00100);
  assign is_stri = (op == 5'b00101);
  assign is_strr = (op == 5'b00110) && (func == 2'b00);
  assign is_cmp  = (op == 5'b00110) && (func == 2'b01);
  assign is_addi = (op == 5'b00111);
  assign is_subi = (op == 5'b01000);
  assign is_mov  = (op == 5'b01011);
  assign is_jmp  = (op == 5'b10000);
  assign is_b    = (op == 5'b11000) || (op == 5'b11001);
  assign is_out  = (op == 5'b11100);

  assign is_ldr  = is_ldri | is_ldrr;
  assign is_str  = is_stri | is_strr;
  assign imm5_op = is_addi | is_subi | is_ldri | is_stri;
  assign known   = is_alu | is_lhi | is_lli | is_ldr | is_str | is_cmp |
                   is_addi | is_subi | is_mov | is_jmp | is_b | is_out;

  // ALU operand/op selects shared by EXEC and MEM (MEM holds the address calc).
  assign ex_srca  = is_alu | is_addi | is_subi | is_mov | is_ldr | is_str;
  assign ex_srcb  = imm5_op ? 2'b10 : (is_mov ? 2'b11 : 2'b00);
  assign ex_aluop = (is_subi | is_cmp) ? 2'b10 : (is_alu ? func : 2'b00);

  // End of an instruction: dropping run parks the FSM in IDLE instead of refetching.
  assign done_nxt = run ? FETCH : IDLE;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    Imm_5or8 = 1'b0;
    RegWrite = 1'b0;
    OutREn   = 1'b0;
    Branch   = 1'b0;
    PSWEn    = 1'b0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    LLorLH   = 1'b0;
    ALUSrcA  = 1'b0;
    JAorJR   = 1'b0;
    ALUop    = 2'b00;
    MemtoReg = 2'b00;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    illegal  = 1'b0;
    if (!rst) begin
      case (cur)
        IDLE: if (run) nxt = FETCH;
        FETCH: begin
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          nxt     = DECODE;
        end
        DECODE: begin
          RegDst = is_lhi | is_str;
          if (is_b) begin
            ALUSrcB  = 2'b10;
            Imm_5or8 = 1'b1;
          end
          if (is_lli | is_lhi) nxt = WB;
          else if (known)      nxt = EXEC;
          else begin
            illegal = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
            nxt = HALT;
`else
            nxt = done_nxt;
`endif
          end
        end
        EXEC: begin
          ALUSrcA = ex_srca;
          ALUSrcB = ex_srcb;
          ALUop   = ex_aluop;
          PSWEn   = is_alu | is_cmp;
          OutREn  = is_out;
          if (is_jmp) begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
          end
          if (is_b) begin
            PCSrc  = 2'b01;
            Branch = 1'b1;
          end
          if (is_ldr | is_str)                        nxt = MEM;
          else if (is_alu | is_addi | is_subi | is_mov) nxt = WB;
          else                                          nxt = done_nxt;
        end
        MEM: begin
          IorD    = 1'b1;
          ALUSrcA = ex_srca;
          ALUSrcB = ex_srcb;
          ALUop   = ex_aluop;
          if (is_str) begin
            MemWrite = 1'b1;
            RegDst   = 1'b1;
            nxt      = done_nxt;
          end else begin
            nxt = WB;
          end
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = is_ldr ? 2'b01 : ((is_lli | is_lhi) ? 2'b10 : 2'b00);
          LLorLH   = is_lhi;
          nxt      = done_nxt;
        end
        HALT: begin
`ifdef CTRL_ILLEGAL_HALT_EN
          illegal = 1'b1;
          nxt     = HALT;
`else
          nxt = IDLE;
`endif
        end
        default: nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state-plan model, directed literals, random run.
module tb_multicycle_ctrl;

`ifdef CTRL_ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_HALT = 6;
  localparam int C_ALU = 0, C_LHI = 1, C_LLI = 2, C_LDRI = 3, C_LDRR = 4, C_STRI = 5, C_STRR = 6,
                 C_CMP = 7, C_ADDI = 8, C_SUBI = 9, C_MOV = 10, C_JMP = 11, C_B = 12, C_OUT = 13,
                 C_BAD = 14;

  logic clk = 1'b0;
  logic rst, run;
  logic [15:0] opcode;
  logic MemWrite, IRWrite, Imm_5or8, RegWrite, OutREn, Branch, PSWEn, PCWrite;
  logic IorD, RegDst, LLorLH, ALUSrcA, JAorJR, illegal;
  logic [1:0] ALUop, MemtoReg, ALUSrcB, PCSrc;
  logic [2:0] state;
  logic [24:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WIDTH(16), .ST_BITS(3)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .Imm_5or8(Imm_5or8), .RegWrite(RegWrite),
    .OutREn(OutREn), .Branch(Branch), .PSWEn(PSWEn), .PCWrite(PCWrite), .IorD(IorD),
    .RegDst(RegDst), .LLorLH(LLorLH), .ALUSrcA(ALUSrcA), .JAorJR(JAorJR),
    .ALUop(ALUop), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .state(state), .illegal(illegal)
  );

  // {state, illegal, 13 strobes, ALUop, MemtoReg, ALUSrcB, PCSrc}
  assign dut_vec = {state, illegal, MemWrite, IRWrite, Imm_5or8, RegWrite, OutREn, Branch, PSWEn,
                    PCWrite, IorD, RegDst, LLorLH, ALUSrcA, JAorJR, ALUop, MemtoReg, ALUSrcB, PCSrc};

  int checks = 0, errors = 0;
  int mst = S_IDLE;
  int plan[$];
  logic [24:0] last_vec;
  logic [24:0] hist [0:7];
  bit rw_seen, mw_seen;

  function automatic int cls(input logic [15:0] o);
    case (o[15:11])
      5'b00000: return C_ALU;
      5'b00001: return C_LHI;
      5'b00010: return C_LLI;
      5'b00011: return C_LDRI;
      5'b00100: return C_LDRR;
      5'b00101: return C_STRI;
      5'b00110: return (o[1:0] == 2'b00) ? C_STRR : ((o[1:0] == 2'b01) ? C_CMP : C_BAD);
      5'b00111: return C_ADDI;
      5'b01000: return C_SUBI;
      5'b01011: return C_MOV;
      5'b10000: return C_JMP;
      5'b11000, 5'b11001: return C_B;
      5'b11100: return C_OUT;
      default:  return C_BAD;
    endcase
  endfunction

  // Expected outputs for a given state while executing an instruction of a given class.
  function automatic logic [24:0] exp_vec(input int st, input logic [15:0] o, input bit r);
    int c;
    bit ldr, str, regop, imm5;
    logic ill, mw, irw, imm, rw, oe, br, psw, pcw, iord, rd, ll, sa;
    logic [1:0] aop, m2r, sb, pcs;
    c = cls(o);
    ldr = (c == C_LDRI) || (c == C_LDRR);
    str = (c == C_STRI) || (c == C_STRR);
    regop = (c == C_ALU) || (c == C_ADDI) || (c == C_SUBI) || (c == C_MOV) || ldr || str;
    imm5 = (c == C_ADDI) || (c == C_SUBI) || (c == C_LDRI) || (c == C_STRI);
    {ill, mw, irw, imm, rw, oe, br, psw, pcw, iord, rd, ll, sa} = '0;
    {aop, m2r, sb, pcs} = '0;
    if (!r) begin
      if (st == S_FETCH) begin
        sb = 2'b01; pcw = 1'b1; irw = 1'b1;
      end else if (st == S_DECODE) begin
        rd  = (c == C_LHI) || str;
        ill = (c == C_BAD);
        if (c == C_B) begin sb = 2'b10; imm = 1'b1; end
      end else if (st == S_EXEC || st == S_MEM) begin
        sa  = regop;
        sb  = imm5 ? 2'b10 : ((c == C_MOV) ? 2'b11 : 2'b00);
        aop = ((c == C_SUBI) || (c == C_CMP)) ? 2'b10 : ((c == C_ALU) ? o[1:0] : 2'b00);
        if (st == S_EXEC) begin
          psw = (c == C_ALU) || (c == C_CMP);
          oe  = (c == C_OUT);
          if (c == C_JMP) begin pcs = 2'b10; pcw = 1'b1; end
          if (c == C_B)   begin pcs = 2'b01; br = 1'b1; end
        end else begin
          iord = 1'b1;
          if (str) begin mw = 1'b1; rd = 1'b1; end
        end
      end else if (st == S_WB) begin
        rw  = 1'b1;
        m2r = ldr ? 2'b01 : (((c == C_LLI) || (c == C_LHI)) ? 2'b10 : 2'b00);
        ll  = (c == C_LHI);
      end else if (st == S_HALT) begin
        ill = HALT_EN;
      end
    end
    return {3'(st), ill, mw, irw, imm, rw, oe, br, psw, pcw, iord, rd, ll, sa, 1'b0, aop, m2r, sb, pcs};
  endfunction

  // States visited after FETCH, straight from the cycles-per-instruction table.
  task automatic build_plan(input logic [15:0] o);
    int c;
    c = cls(o);
    plan.delete();
    plan.push_back(S_DECODE);
    case (c)
      C_LHI, C_LLI: plan.push_back(S_WB);
      C_CMP, C_OUT, C_B, C_JMP: plan.push_back(S_EXEC);
      C_ALU, C_ADDI, C_SUBI, C_MOV: begin plan.push_back(S_EXEC); plan.push_back(S_WB); end
      C_STRI, C_STRR: begin plan.push_back(S_EXEC); plan.push_back(S_MEM); end
      C_LDRI, C_LDRR: begin plan.push_back(S_EXEC); plan.push_back(S_MEM); plan.push_back(S_WB); end
      default: ;
    endcase
  endtask

  task automatic model_step(input bit r, input bit rn, input logic [15:0] o);
    if (r) begin
      mst = S_IDLE;
      plan.delete();
    end else if (mst == S_IDLE) begin
      if (rn) mst = S_FETCH;
    end else if (mst == S_FETCH) begin
      build_plan(o);
      mst = plan.pop_front();
    end else if (mst != S_HALT) begin
      if (plan.size() != 0)                          mst = plan.pop_front();
      else if (cls(o) == C_BAD && HALT_EN)           mst = S_HALT;
      else                                           mst = rn ? S_FETCH : S_IDLE;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance both.
  task automatic cycle(input bit r, input bit rn, input logic [15:0] o);
    logic [24:0] e;
    rst = r; run = rn; opcode = o;
    #1;
    e = exp_vec(mst, o, r);
    last_vec = dut_vec;
    hist[dut_vec[24:22]] = dut_vec;
    if (RegWrite) rw_seen = 1'b1;
    if (MemWrite) mw_seen = 1'b1;
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL cycle t=%0t op=%h: got %h expected %h", $time, o, dut_vec, e);
    end
    @(posedge clk);
    model_step(r, rn, o);
    @(negedge clk);
  endtask

  // Runs one instruction starting in FETCH; returns the cycle count back to FETCH.
  task automatic run_instr(input logic [15:0] o, output int n);
    n = 0;
    rw_seen = 1'b0; mw_seen = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    do begin
      cycle(1'b0, 1'b1, o);
      n++;
    end while (state != 3'd1 && n < 12);
  endtask

  function automatic logic [15:0] pick_op();
    logic [4:0] ops [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd11,
                             5'd16, 5'd24, 5'd25, 5'd28};
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(9) == 0) return r;
    return {ops[$urandom_range(13)], r[10:0]};
  endfunction

  initial begin
    int n;
    logic [15:0] cur_op;
    rst = 1'b1; run = 1'b0; opcode = 16'h0000;
    @(posedge clk);
    model_step(1'b1, 1'b0, 16'h0000);
    @(negedge clk);

    cycle(1'b1, 1'b1, 16'h1025);
    cycle(1'b1, 1'b1, 16'h1025);
    chk("rst_outputs_zero", int'(last_vec[21:0]), 0);
    cycle(1'b0, 1'b1, 16'h1025);
    chk("post_rst_state", int'(state), S_FETCH);
    chk("fetch_pcwrite", int'(PCWrite), 1);
    chk("fetch_irwrite", int'(IRWrite), 1);
    chk("fetch_alusrcb", int'(ALUSrcB), 1);

    run_instr(16'h1025, n);
    chk("lli_cycles", n, 3);
    chk("lli_wb_memtoreg", int'(hist[S_WB][5:4]), 2);
    chk("lli_wb_llorlh", int'(hist[S_WB][10]), 0);
    run_instr(16'h0863, n);
    chk("lhi_wb_llorlh", int'(hist[S_WB][10]), 1);
    run_instr(16'h1A01, n);
    chk("ldr_cycles", n, 5);
    chk("ldr_exec_alusrcb", int'(hist[S_EXEC][3:2]), 2);
    chk("ldr_mem_iord", int'(hist[S_MEM][12]), 1);
    chk("ldr_wb_memtoreg", int'(hist[S_WB][5:4]), 1);
    run_instr(16'h2C03, n);
    chk("str_cycles", n, 4);
    chk("str_memwrite", int'(mw_seen), 1);
    chk("str_no_regwrite", int'(rw_seen), 0);
    run_instr(16'h032A, n);
    chk("sub_cycles", n, 4);
    chk("sub_exec_aluop", int'(hist[S_EXEC][7:6]), 2);
    chk("sub_exec_pswen", int'(hist[S_EXEC][14]), 1);
    run_instr(16'h3029, n);
    chk("cmp_cycles", n, 3);
    chk("cmp_exec_pswen", int'(hist[S_EXEC][14]), 1);
    chk("cmp_no_regwrite", int'(rw_seen), 0);
    run_instr(16'hCE03, n);
    chk("b_cycles", n, 3);
    chk("b_dec_imm", int'(hist[S_DECODE][18]), 1);
    chk("b_exec_pcsrc", int'(hist[S_EXEC][1:0]), 1);
    chk("b_exec_branch", int'(hist[S_EXEC][15]), 1);
    run_instr(16'h8035, n);
    chk("jmp_cycles", n, 3);
    chk("jmp_exec_pcsrc", int'(hist[S_EXEC][1:0]), 2);
    chk("jmp_exec_pcwrite", int'(hist[S_EXEC][13]), 1);

    if (HALT_EN) begin
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'hF800);
      chk("illegal_halt_state", int'(state), S_HALT);
      chk("illegal_halt_flag", int'(illegal), 1);
    end else begin
      run_instr(16'hF800, n);
      chk("illegal_nop_cycles", n, 2);
      chk("illegal_dec_pulse", int'(hist[S_DECODE][21]), 1);
      chk("illegal_after_pulse", int'(illegal), 0);
    end
    cycle(1'b1, 1'b1, 16'h1A01);
    cycle(1'b0, 1'b1, 16'h1A01);
    rw_seen = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1A01);
    chk("ldr_reach_mem", int'(state), S_MEM);
    cycle(1'b1, 1'b1, 16'h1A01);
    chk("rst_mid_state", int'(state), S_IDLE);
    cycle(1'b0, 1'b0, 16'h1A01);
    chk("rst_mid_no_regwrite", int'(rw_seen), 0);

    cur_op = pick_op();
    for (int i = 0; i < 4000; i++) begin
      bit r, rn;
      if (mst == S_IDLE || mst == S_FETCH) cur_op = pick_op();
      r  = ($urandom_range(79) == 0);
      rn = ($urandom_range(7) != 0);
      cycle(r, rn, cur_op);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
